sig_filter_mc: RTL and testbench

Parametrised multi-channel glitch filter and debouncer, the successor to the single-bit `filter` block. Each channel synchronises an asynchronous input and moves its output to a new level only after that level has been stable for a run-time-programmable number of clocks. On each output change the channel emits a one-cycle rise or fall pulse. An optional fast-rise mode passes rising edges after synchronisation only. The block sits between raw board-level inputs (buttons, switches, noisy status lines) and the control logic, and replaces per-signal `filter` instances.

---
 rtl/sig_filter_mc.sv | 86 ++++++++
 tb/tb_sig_filter_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_filter_mc.sv
// Multi-channel glitch filter / debouncer: 2-flop synchroniser per channel, programmable
// stability count before the output follows, and one-cycle rise/fall pulses on each change.
module sig_filter_mc #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 4,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                fast_rise,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CNT_W-1:0]    teff_m1;

    // A threshold of 0 behaves as 1, so the compare limit never underflows.
    assign teff_m1 = (threshold == '0) ? '0 : threshold - CNT_W'(1);

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (enable) begin
                if (s2_q[i] != out_q[i]) begin
                    if ((cnt_q[i] >= teff_m1) || (fast_rise && s2_q[i])) begin
                        out_d[i]  = s2_q[i];
                        rise_d[i] = s2_q[i];
                        fall_d[i] = ~s2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q   <= {CHANNELS{RESET_VAL}};
            s2_q   <= {CHANNELS{RESET_VAL}};
            out_q  <= {CHANNELS{RESET_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sig_in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign sig_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: tb/tb_sig_filter_mc.sv
// Bench for sig_filter_mc: directed test-plan steps plus random traffic, every cycle compared
// against a run-length model of the filter rules.
module tb_sig_filter_mc;

    localparam int CH = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          fast_rise;
    logic [CW-1:0] threshold;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] sig_out, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    // Model: synchroniser as a two-stage delay line, plus the length of the current run of
    // enabled edges on which the synchronised level disagreed with the output.
    logic [CH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    int            m_run [CH];
    int            dut_rises [CH];

    sig_filter_mc #(
        .CHANNELS  (CH),
        .CNT_W     (CW),
        .RESET_VAL (1'b0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .fast_rise (fast_rise),
        .threshold (threshold),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
    endtask

    function automatic logic [CH-1:0] m_busy();
        logic [CH-1:0] b;
        for (int c = 0; c < CH; c++) b[c] = (m_run[c] != 0);
        return b;
    endfunction

    task automatic model_edge();
        int teff;
        if (!reset) begin
            model_reset();
            return;
        end
        teff   = (threshold == 0) ? 1 : int'(threshold);
        m_rise = '0;
        m_fall = '0;
        if (enable) begin
            for (int c = 0; c < CH; c++) begin
                if (m_s2[c] != m_out[c]) begin
                    if (m_run[c] + 1 >= teff || (fast_rise && m_s2[c])) begin
                        m_out[c]  = m_s2[c];
                        m_rise[c] = m_s2[c];
                        m_fall[c] = !m_s2[c];
                        m_run[c]  = 0;
                    end else begin
                        m_run[c]++;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = sig_in;
    endtask

    task automatic compare_all(input string tag);
        check_vec({tag, ".sig_out"}, sig_out, m_out);
        check_vec({tag, ".rise"}, rise, m_rise);
        check_vec({tag, ".fall"}, fall, m_fall);
        check_vec({tag, ".busy"}, busy, m_busy());
    endtask

    // One clock: inputs were set on the previous falling edge; compare on the next one.
    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        for (int c = 0; c < CH; c++) if (rise[c] === 1'b1) dut_rises[c]++;
        compare_all("cycle");
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic edges_until(input int ch, input logic lvl, input int bound, output int n);
        n = 0;
        while (n <= bound && sig_out[ch] !== lvl) begin
            tick();
            n++;
        end
    endtask

    int n;
    int r0;

    initial begin
        reset = 1'b0; enable = 1'b1; fast_rise = 1'b0; threshold = 4'd3; sig_in = 4'hF;
        for (int c = 0; c < CH; c++) dut_rises[c] = 0;
        model_reset();

        // Reset holds everything at its reset value despite input activity.
        @(negedge clock);
        compare_all("reset");
        for (int k = 0; k < 4; k++) begin
            sig_in = ~sig_in;
            tick();
        end
        sig_in = 4'h0;
        ticks(2);
        reset = 1'b1;
        ticks(4);
        check_vec("after_reset.sig_out", sig_out, 4'h0);

        // Basic rise and fall with T=3: 5-edge latency.
        sig_in[0] = 1'b1;
        edges_until(0, 1'b1, 20, n);
        check_int("basic_rise_latency", n, 5);
        ticks(3);
        sig_in[0] = 1'b0;
        edges_until(0, 1'b0, 20, n);
        check_int("basic_fall_latency", n, 5);
        ticks(2);

        // Glitch rejection on channel 1: runs of 1 and 2 clocks never pass T=3.
        for (int k = 0; k < 27; k++) begin
            sig_in[1] = ~sig_in[1];
            ticks((k % 2 == 0) ? 1 : 2);
        end
        sig_in[1] = 1'b0;
        ticks(4);
        check_vec("glitch_train.sig_out", sig_out, 4'h0);
        check_int("glitch_train.rises", dut_rises[1], 0);
        sig_in[1] = 1'b1;
        ticks(2);
        sig_in[1] = 1'b0;
        ticks(6);
        check_int("short_pulse.rises", dut_rises[1], 0);
        sig_in[1] = 1'b1;
        ticks(4);
        sig_in[1] = 1'b0;
        ticks(8);
        check_int("long_pulse.rises", dut_rises[1], 1);

        // Fast rise with T=10: 3 edges up, 12 edges down.
        fast_rise = 1'b1; threshold = 4'd10;
        sig_in[2] = 1'b1;
        edges_until(2, 1'b1, 30, n);
        check_int("fast_rise_latency", n, 3);
        ticks(2);
        sig_in[2] = 1'b0;
        edges_until(2, 1'b0, 30, n);
        check_int("fast_rise_fall_latency", n, 12);
        fast_rise = 1'b0;
        ticks(2);

        // Enable pause: 4 mismatching edges, 5 frozen clocks, then 4 more edges.
        threshold = 4'd8;
        sig_in[0] = 1'b1;
        ticks(6);
        enable = 1'b0;
        ticks(5);
        check_vec("paused.busy", busy & 4'h1, 4'h1);
        enable = 1'b1;
        edges_until(0, 1'b1, 20, n);
        check_int("enable_resume_latency", n, 4);
        ticks(2);

        // Lowering T below the running count updates on the next edge.
        sig_in[0] = 1'b0;
        ticks(7);
        threshold = 4'd2;
        edges_until(0, 1'b0, 20, n);
        check_int("threshold_drop_latency", n, 1);
        ticks(2);

        // T=0 behaves as T=1.
        threshold = 4'd0;
        sig_in[0] = 1'b1;
        edges_until(0, 1'b1, 20, n);
        check_int("t0_latency", n, 3);
        sig_in[0] = 1'b0;
        ticks(5);

        // Asynchronous reset mid-count clears state at once, with no pulse.
        threshold = 4'd8;
        sig_in[3] = 1'b1;
        ticks(5);
        check_vec("pre_reset.busy3", busy & 4'h8, 4'h8);
        #2 reset = 1'b0;
        model_reset();
        #1 compare_all("async_reset");
        sig_in = 4'h0;
        @(negedge clock);
        reset = 1'b1;
        ticks(3);

        // All channels rise together with T=2.
        threshold = 4'd2;
        sig_in = 4'hF;
        n = 0;
        while (n <= 10 && rise === 4'h0) begin
            tick();
            n++;
        end
        check_vec("simultaneous_rise", rise, 4'hF);
        check_int("simultaneous_latency", n, 4);
        ticks(2);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if (k % 64 == 0) threshold = CW'($urandom_range(0, 15));
            if (k % 200 == 0) fast_rise = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < CH; c++) begin
                r0 = $urandom_range(0, 7);
                if (r0 == 0) sig_in[c] = ~sig_in[c];
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
